// File: rtl/bcd_msd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Also reports the most significant nonzero decimal digit and its position.
module bcd_msd_seq #(
  parameter int W = 8,
  parameter int D = 3,
  localparam int IW = (D > 1) ? $clog2(D) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic            busy,
  output logic            done,
  output logic [4*D-1:0]  bcd,
  output logic [3:0]      msd,
  output logic [IW-1:0]   msd_idx
);

  localparam int SW = 4 * D + W;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]     state;
  logic [SW-1:0]  sr;
  logic [SW-1:0]  sr_adj;
  logic [SW-1:0]  sr_shift;
  logic [CW-1:0]  cnt;
  logic [4*D-1:0] final_digits;
  logic [3:0]     msd_comb;
  logic [IW-1:0]  msd_idx_comb;

  // All digit fields are corrected in parallel from the current register value.
  assign sr_adj[W-1:0] = sr[W-1:0];

  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_add3
      logic [3:0] digit;
      assign digit = sr[W + 4*gi +: 4];
      assign sr_adj[W + 4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  endgenerate

  assign sr_shift     = sr_adj << 1;
  assign final_digits = sr_shift[SW-1:W];

  // Later (more significant) nonzero digits override earlier ones.
  always_comb begin
    msd_comb     = 4'd0;
    msd_idx_comb = '0;
    for (int k = 0; k < D; k++) begin
      if (final_digits[4*k +: 4] != 4'd0) begin
        msd_comb     = final_digits[4*k +: 4];
        msd_idx_comb = IW'(k);
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      bcd     <= '0;
      msd     <= 4'd0;
      msd_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sr    <= {{(4*D){1'b0}}, bin};
            cnt   <= CW'(W);
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sr  <= sr_shift;
          cnt <= cnt - CW'(1);
          // Last shift: publish results from the value being shifted in now.
          if (cnt == CW'(1)) begin
            state   <= DONE;
            bcd     <= final_digits;
            msd     <= msd_comb;
            msd_idx <= msd_idx_comb;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_msd_seq.sv
// Directed bench for bcd_msd_seq: default 8-bit/3-digit instance plus a 5-bit/2-digit sweep.
module tb_bcd_msd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start2;
  logic [7:0]  bin;
  logic [4:0]  bin2;
  logic        busy, done, busy2, done2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;
  logic [3:0]  msd, msd2;
  logic [1:0]  msd_idx;
  logic [0:0]  msd_idx2;

  int errors = 0;
  int checks = 0;

  bcd_msd_seq #(.W(8), .D(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .msd(msd), .msd_idx(msd_idx)
  );

  bcd_msd_seq #(.W(5), .D(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .msd(msd2), .msd_idx(msd_idx2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Start a conversion on dut; return cycles until done is seen and busy-cycle count.
  task automatic conv(input logic [7:0] v, output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
    end
    $display("conv bin=%0d lat=%0d busy_cycles=%0d bcd=%03h msd=%0d msd_idx=%0d",
             v, lat, nbusy, bcd, msd, msd_idx);
  endtask

  task automatic conv2(input logic [4:0] v, output int lat);
    @(negedge clk);
    start2 = 1'b1;
    bin2   = v;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat    = 1;
    while (!done2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("conv2 bin=%0d lat=%0d bcd=%02h msd=%0d msd_idx=%0d", v, lat, bcd2, msd2, msd_idx2);
  endtask

  task automatic check_result(input string tag, input logic [11:0] e_bcd,
                              input logic [3:0] e_msd, input logic [1:0] e_idx);
    chk({tag, "_bcd"}, 32'(bcd), 32'(e_bcd));
    chk({tag, "_msd"}, 32'(msd), 32'(e_msd));
    chk({tag, "_idx"}, 32'(msd_idx), 32'(e_idx));
  endtask

  initial begin
    int lat, nbusy, ndone, first_at, second_at, cyc;
    logic prev_done;
    logic [11:0] bcd_first, bcd_second;
    logic [3:0] tens, units;

    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    bin    = '0;
    bin2   = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_msd", 32'(msd), 32'd0);
    chk("rst_idx", 32'(msd_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero input: latency and busy window
    conv(8'd0, lat, nbusy);
    chk("zero_lat", 32'(lat), 32'd9);
    chk("zero_busy_cycles", 32'(nbusy), 32'd8);
    check_result("zero", 12'h000, 4'd0, 2'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);

    conv(8'd255, lat, nbusy);
    chk("v255_lat", 32'(lat), 32'd9);
    check_result("v255", 12'h255, 4'd2, 2'd2);
    conv(8'd47, lat, nbusy);
    check_result("v47", 12'h047, 4'd4, 2'd1);
    conv(8'd9, lat, nbusy);
    check_result("v9", 12'h009, 4'd9, 2'd0);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    chk("v100_hold_bcd", 32'(bcd), 32'h009);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd33;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    $display("ignore_test ndone=%0d bcd=%03h msd=%0d msd_idx=%0d", ndone, bcd, msd, msd_idx);
    chk("ignore_ndone", 32'(ndone), 32'd1);
    check_result("v100", 12'h100, 4'd1, 2'd2);

    // Back-to-back with start held high
    @(negedge clk);
    start     = 1'b1;
    bin       = 8'd200;
    first_at  = -1;
    second_at = -1;
    prev_done = 1'b0;
    bcd_first = '0;
    bcd_second = '0;
    cyc       = 0;
    while (second_at < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done && prev_done) chk("b2b_done_consecutive", 32'd1, 32'd0);
      if (done) begin
        if (first_at < 0) begin
          first_at  = cyc;
          bcd_first = bcd;
          bin       = 8'd7;
        end else begin
          second_at  = cyc;
          bcd_second = bcd;
          start      = 1'b0;
        end
      end
      prev_done = done;
    end
    start = 1'b0;
    $display("b2b first=%0d second=%0d bcd1=%03h bcd2=%03h", first_at, second_at, bcd_first, bcd_second);
    chk("b2b_gap", 32'(second_at - first_at), 32'd9);
    chk("b2b_bcd1", 32'(bcd_first), 32'h200);
    chk("b2b_bcd2", 32'(bcd_second), 32'h007);
    @(posedge clk); #1;
    chk("b2b_done_after", 32'(done), 32'd0);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd123;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("async_reset busy=%0d done=%0d bcd=%03h msd=%0d", busy, done, bcd, msd);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_bcd", 32'(bcd), 32'd0);
    chk("arst_msd", 32'(msd), 32'd0);
    chk("arst_idx", 32'(msd_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    conv(8'd58, lat, nbusy);
    chk("v58_lat", 32'(lat), 32'd9);
    check_result("v58", 12'h058, 4'd5, 2'd1);

    // Narrow instance sweep
    for (int v = 0; v < 32; v++) begin
      conv2(5'(v), lat);
      tens  = 4'(v / 10);
      units = 4'(v % 10);
      chk("w5_lat", 32'(lat), 32'd6);
      chk("w5_bcd", 32'(bcd2), 32'({tens, units}));
      chk("w5_msd", 32'(msd2), (v < 10) ? 32'(units) : 32'(tens));
      chk("w5_idx", 32'(msd_idx2), (v < 10) ? 32'd0 : 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_msd_seq.md
Name: bcd_msd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.
- Produces all D decimal digits of a W-bit unsigned input, plus the most significant nonzero digit and its position.
- Sits between datapath results and display/digit-select logic.
- Start/busy/done handshake; results held until the next conversion completes.

Parameters:
- W, 8, input binary width (W >= 1).
- D, 3, number of BCD digits produced. Integrator guarantees 10^D > 2^W - 1; RTL does not check this.
- IW, $clog2(D) (minimum 1), width of msd_idx. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion of bin; sampled on rising edge
- bin  input  W  unsigned value; captured only on an accepted start
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse: bcd/msd/msd_idx just updated
- bcd  output  4*D  digit k in bcd[4k+3:4k]; k=0 is units
- msd  output  4  most significant nonzero digit; 0 when value is 0
- msd_idx  output  IW  index k of msd; 0 when value is 0

Behaviour:
- Reset: rst_n low forces, asynchronously, state=IDLE, busy=0, done=0, bcd=0, msd=0, msd_idx=0, and clears the internal shift register and counter.
- States:
  - IDLE: waiting for start.
  - SHIFT: W iterations.
  - DONE: 1 cycle.
- IDLE/DONE + start=1 at edge k:
  - Capture bin into the low W bits of a (4D+W)-bit shift register; digit field cleared.
  - Bit counter = W; go to SHIFT.
  - busy=1 from edge k.
- IDLE + start=0: stay in IDLE.
- DONE + start=0: go to IDLE.
- SHIFT, each edge:
  - Every 4-bit digit field >= 5 gets +3 (all fields evaluated in parallel from current values).
  - Then the whole register shifts left by 1.
  - Counter decrements.
  - After the W-th shift (edge k+W), go to DONE.
- Entry to DONE (edge k+W):
  - busy=0, done=1.
  - bcd, msd and msd_idx are loaded in the same edge from the final digit field.
  - done is high for exactly one cycle unless a new conversion chains (done is never high two consecutive cycles).
- Latency: start sampled at edge k -> done high after edge k+W, i.e. W+1 clock cycles from the start request to done visible.
- Throughput: back-to-back start held high gives one result every W+1 cycles (start accepted in the DONE cycle).
- start while busy=1 is ignored; bin changes during SHIFT have no effect.
- msd/msd_idx:
  - Scan from digit D-1 down to 0; the first nonzero digit wins.
  - If all digits are zero: msd=0, msd_idx=0.
  - For values < 10: msd=digit 0, msd_idx=0.
- Outputs bcd/msd/msd_idx are registered and hold their value between done pulses, including throughout the next conversion.
- Reset mid-conversion: immediate abort; all outputs return to reset values; no done pulse; the next start after reset release converts normally.
- The add-3 step never overflows a digit field when 10^D > 2^W - 1; overflow beyond digit D-1 is discarded.

Test Plan:
- Defaults, start with bin=0 -> done after 9 cycles; bcd=12'h000, msd=0, msd_idx=0; busy high for exactly 8 cycles.
- bin=255 -> bcd=12'h255, msd=2, msd_idx=2. bin=47 -> bcd=12'h047, msd=4, msd_idx=1. bin=9 -> bcd=12'h009, msd=9, msd_idx=0.
- Start with bin=100, then pulse start with bin=33 on the 3rd busy cycle -> only one done; bcd=12'h100, msd=1, msd_idx=2; outputs unchanged afterwards.
- start held high, bin=200 then bin=7 presented at the done cycle -> two done pulses 9 cycles apart; bcd=12'h200 then 12'h007; done never high in consecutive cycles.
- Start with bin=123, assert rst_n=0 at the 4th busy cycle -> busy/done/bcd/msd go to 0 immediately, without waiting for a clock edge; after release, bin=58 -> bcd=12'h058, msd=5, msd_idx=1.
- Instance W=5, D=2, sweep bin=0..31 -> bcd matches decimal; msd = bin for bin<10, else bin/10 (e.g. 31 -> msd=3, msd_idx=1).
